// File: rtl/ddr100_wr_sched.sv
// ddr100_wr_sched: write-burst scheduler for the 100 MHz DDR PHY.
// Every accepted write start is pushed into a shift register. Each output is
// a registered OR over a fixed window of that history. Overlapping or
// back-to-back bursts therefore merge naturally, and no per-burst state
// machine is needed.
module ddr100_wr_sched #(
  parameter int DQ_WIDTH = 16,
  parameter int DM_WIDTH = 2,
  parameter int WL       = 5
) (
  input  logic                    clk100m,
  input  logic                    phy_rst,
  input  logic                    wr_start,
  output logic                    wd_rd,
  input  logic [2*DQ_WIDTH-1:0]   wd_data,
  input  logic [2*DM_WIDTH-1:0]   wd_mask,
  output logic [DQ_WIDTH-1:0]     wdata_p0,
  output logic [DQ_WIDTH-1:0]     wdata_p1,
  output logic [DM_WIDTH-1:0]     wdm_p0,
  output logic [DM_WIDTH-1:0]     wdm_p1,
  output logic                    dq_oe,
  output logic                    dqs_oe,
  output logic                    dqs_en,
  output logic                    busy,
  output logic                    wr_done,
  output logic                    err_tccd
);

  // History depth: bit i of hist_s is set at edge En when a burst started at E(n-i).
  localparam int DEPTH = WL + 5;

  // Start history. It only needs bits up to WL+3, because bit WL+4 is the
  // last tap and is consumed straight out of hist_s.
  logic [DEPTH-2:0] sr_r;
  logic [DEPTH-1:0] hist_s;

  logic acc_s;
  logic viol_s;
  logic rd_win_s;
  logic dat_win_s;
  logic dqs_win_s;
  logic busy_win_s;
  logic done_tap_s;

  logic                viol_r;
  logic                err_r;
  logic                wd_rd_r;
  logic [DQ_WIDTH-1:0] wdata_p0_r;
  logic [DQ_WIDTH-1:0] wdata_p1_r;
  logic [DM_WIDTH-1:0] wdm_p0_r;
  logic [DM_WIDTH-1:0] wdm_p1_r;
  logic                dq_oe_r;
  logic                dqs_oe_r;
  logic                dqs_en_r;
  logic                busy_r;
  logic                wr_done_r;

  // Accept or drop the start pulse (tCCD check), and form the output tap windows.
  always_comb begin
    viol_s     = wr_start & (|sr_r[2:0]);
    acc_s      = wr_start & ~(|sr_r[2:0]);
    hist_s     = {sr_r, acc_s};
    rd_win_s   = |hist_s[WL+1:WL-2];
    dat_win_s  = |hist_s[WL+3:WL];
    dqs_win_s  = |hist_s[WL+4:WL-1];
    busy_win_s = |hist_s[WL+4:1];
    done_tap_s = hist_s[WL+4];
  end

  // Shift the start history forward one cycle.
  always_ff @(posedge clk100m) begin
    if (phy_rst) begin
      sr_r <= '0;
    end else begin
      sr_r <= hist_s[DEPTH-2:0];
    end
  end

  // Register the control strobes from their tap windows.
  always_ff @(posedge clk100m) begin
    if (phy_rst) begin
      wd_rd_r   <= 1'b0;
      dq_oe_r   <= 1'b0;
      dqs_en_r  <= 1'b0;
      dqs_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      wr_done_r <= 1'b0;
    end else begin
      wd_rd_r   <= rd_win_s;
      dq_oe_r   <= dat_win_s;
      dqs_en_r  <= dat_win_s;
      dqs_oe_r  <= dqs_win_s;
      busy_r    <= busy_win_s;
      wr_done_r <= done_tap_s;
    end
  end

  // Capture buffer data into the beat registers during the data window. Otherwise hold idle values.
  always_ff @(posedge clk100m) begin
    if (phy_rst) begin
      wdata_p0_r <= '0;
      wdata_p1_r <= '0;
      wdm_p0_r   <= {DM_WIDTH{1'b1}};
      wdm_p1_r   <= {DM_WIDTH{1'b1}};
    end else if (dat_win_s) begin
      wdata_p0_r <= wd_data[DQ_WIDTH-1:0];
      wdata_p1_r <= wd_data[2*DQ_WIDTH-1:DQ_WIDTH];
      wdm_p0_r   <= wd_mask[DM_WIDTH-1:0];
      wdm_p1_r   <= wd_mask[2*DM_WIDTH-1:DM_WIDTH];
    end else begin
      wdata_p0_r <= '0;
      wdata_p1_r <= '0;
      wdm_p0_r   <= {DM_WIDTH{1'b1}};
      wdm_p1_r   <= {DM_WIDTH{1'b1}};
    end
  end

  // Sticky tCCD error. It appears one cycle after the dropped start is registered.
  always_ff @(posedge clk100m) begin
    if (phy_rst) begin
      viol_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      viol_r <= viol_s;
      err_r  <= err_r | viol_r;
    end
  end

  assign wd_rd    = wd_rd_r;
  assign wdata_p0 = wdata_p0_r;
  assign wdata_p1 = wdata_p1_r;
  assign wdm_p0   = wdm_p0_r;
  assign wdm_p1   = wdm_p1_r;
  assign dq_oe    = dq_oe_r;
  assign dqs_oe   = dqs_oe_r;
  assign dqs_en   = dqs_en_r;
  assign busy     = busy_r;
  assign wr_done  = wr_done_r;
  assign err_tccd = err_r;

endmodule

// File: tb/tb_ddr100_wr_sched.sv
// Testbench for ddr100_wr_sched. The bench keeps a list of accepted start
// cycles. Each cycle it derives the expected outputs from each burst's offset.
// Directed bursts are followed by randomized traffic.
module tb_ddr100_wr_sched;

  localparam int WL  = 5;
  localparam int DQW = 16;
  localparam int DMW = 2;
  localparam int NMAX = 8192;
  localparam int B_RD = 6, B_OE = 5, B_DQS = 4, B_EN = 3, B_BUSY = 2, B_DONE = 1, B_ERR = 0;

  logic             clk100m = 1'b0;
  logic             phy_rst = 1'b1;
  logic             wr_start = 1'b0;
  logic             wd_rd;
  logic [2*DQW-1:0] wd_data = '0;
  logic [2*DMW-1:0] wd_mask = '0;
  logic [DQW-1:0]   wdata_p0, wdata_p1;
  logic [DMW-1:0]   wdm_p0, wdm_p1;
  logic             dq_oe, dqs_oe, dqs_en, busy, wr_done, err_tccd;

  ddr100_wr_sched #(.DQ_WIDTH(DQW), .DM_WIDTH(DMW), .WL(WL)) dut (
    .clk100m(clk100m), .phy_rst(phy_rst), .wr_start(wr_start), .wd_rd(wd_rd),
    .wd_data(wd_data), .wd_mask(wd_mask), .wdata_p0(wdata_p0), .wdata_p1(wdata_p1),
    .wdm_p0(wdm_p0), .wdm_p1(wdm_p1), .dq_oe(dq_oe), .dqs_oe(dqs_oe), .dqs_en(dqs_en),
    .busy(busy), .wr_done(wr_done), .err_tccd(err_tccd)
  );

  always #5 clk100m = ~clk100m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts[$];
  int last_acc = -100;
  int err_from = -1;
  logic [2*DQW-1:0] drv_data [0:NMAX-1];
  logic [2*DMW-1:0] drv_mask [0:NMAX-1];
  logic [6:0]       ob_ctl   [0:NMAX-1];
  logic [DQW-1:0]   ob_p0    [0:NMAX-1];
  logic [DQW-1:0]   ob_p1    [0:NMAX-1];
  logic [DMW-1:0]   ob_m1    [0:NMAX-1];
  logic rd_cur = 1'b0, rd_prev = 1'b0;
  logic mode_dir = 1'b0;
  int tbl_idx = 0;
  logic [2*DQW-1:0] tbl_d [0:3];
  logic [2*DMW-1:0] tbl_m [0:3];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Compare every output of the current cycle against the burst-list model.
  task automatic check_cycle();
    logic e_rd, e_win, e_dqs, e_done, e_busy, e_err;
    logic [2*DQW-1:0] e_d;
    logic [2*DMW-1:0] e_m;
    e_rd = 0; e_win = 0; e_dqs = 0; e_done = 0; e_busy = 0;
    foreach (starts[i]) begin
      int d;
      d = cyc - starts[i];
      if (d >= WL-2 && d <= WL+1) e_rd = 1;
      if (d >= WL   && d <= WL+3) e_win = 1;
      if (d >= WL-1 && d <= WL+4) e_dqs = 1;
      if (d >= 1    && d <= WL+4) e_busy = 1;
      if (d == WL+4) e_done = 1;
    end
    e_err = (err_from >= 0) && (cyc >= err_from);
    e_d = e_win ? drv_data[cyc-1] : '0;
    e_m = e_win ? drv_mask[cyc-1] : '1;
    cmp("wd_rd", 32'(wd_rd), 32'(e_rd));
    cmp("dq_oe", 32'(dq_oe), 32'(e_win));
    cmp("dqs_en", 32'(dqs_en), 32'(e_win));
    cmp("dqs_oe", 32'(dqs_oe), 32'(e_dqs));
    cmp("busy", 32'(busy), 32'(e_busy));
    cmp("wr_done", 32'(wr_done), 32'(e_done));
    cmp("err_tccd", 32'(err_tccd), 32'(e_err));
    cmp("wdata", {wdata_p1, wdata_p0}, e_d);
    cmp("wdm", 32'({wdm_p1, wdm_p0}), 32'(e_m));
    ob_ctl[cyc] = {wd_rd, dq_oe, dqs_oe, dqs_en, busy, wr_done, err_tccd};
    ob_p0[cyc] = wdata_p0;
    ob_p1[cyc] = wdata_p1;
    ob_m1[cyc] = wdm_p1;
    rd_prev = rd_cur;
    rd_cur = wd_rd;
  endtask

  // Drive inputs for the next edge, update the model, advance one cycle, then check.
  task automatic step(input logic st, input logic rs);
    int e;
    logic [2*DQW-1:0] d;
    logic [2*DMW-1:0] m;
    if (mode_dir && rd_prev && tbl_idx < 4) begin
      d = tbl_d[tbl_idx];
      m = tbl_m[tbl_idx];
      tbl_idx++;
    end else begin
      d = $urandom();
      m = 4'($urandom_range(0, 15));
    end
    wr_start = st; phy_rst = rs; wd_data = d; wd_mask = m;
    drv_data[cyc] = d; drv_mask[cyc] = m;
    e = cyc + 1;
    if (rs) begin
      starts.delete(); last_acc = -100; err_from = -1;
    end else if (st) begin
      if (e - last_acc <= 3) begin
        if (err_from < 0) err_from = e + 1;
      end else begin
        starts.push_back(e); last_acc = e;
      end
    end
    @(posedge clk100m);
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  function automatic logic ctl(input int c, input int b);
    logic [6:0] v;
    v = ob_ctl[c];
    return v[b];
  endfunction

  initial begin
    int s;
    int nrd;
    tbl_d[0] = 32'h2222_1111; tbl_d[1] = 32'h4444_3333;
    tbl_d[2] = 32'h6666_5555; tbl_d[3] = 32'h8888_7777;
    tbl_m[0] = 4'b0000; tbl_m[1] = 4'b1000; tbl_m[2] = 4'b0000; tbl_m[3] = 4'b0000;

    @(posedge clk100m);
    #1;
    cyc = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(3);

    // Single burst with table data and the mask pattern in the second read.
    mode_dir = 1'b1; tbl_idx = 0;
    s = cyc + 1;
    step(1'b1, 1'b0);
    idle(12);
    mode_dir = 1'b0;
    cmp("pin_rd_pre", 32'(ctl(s+2, B_RD)), 32'd0);
    cmp("pin_rd_first", 32'(ctl(s+3, B_RD)), 32'd1);
    cmp("pin_rd_last", 32'(ctl(s+6, B_RD)), 32'd1);
    cmp("pin_rd_post", 32'(ctl(s+7, B_RD)), 32'd0);
    cmp("pin_p0_first", 32'(ob_p0[s+5]), 32'h1111);
    cmp("pin_p1_first", 32'(ob_p1[s+5]), 32'h2222);
    cmp("pin_p0_last", 32'(ob_p0[s+8]), 32'h7777);
    cmp("pin_m1_masked", 32'(ob_m1[s+6]), 32'd2);
    cmp("pin_m1_open", 32'(ob_m1[s+7]), 32'd0);
    cmp("pin_m1_idle", 32'(ob_m1[s+9]), 32'd3);
    cmp("pin_dqs_pre", 32'(ctl(s+4, B_DQS)), 32'd1);
    cmp("pin_dqs_post", 32'(ctl(s+9, B_DQS)), 32'd1);
    cmp("pin_dqs_off", 32'(ctl(s+10, B_DQS)), 32'd0);
    cmp("pin_done", 32'(ctl(s+9, B_DONE)), 32'd1);
    cmp("pin_busy_end", 32'(ctl(s+10, B_BUSY)), 32'd0);

    // Seamless pair with starts four cycles apart.
    s = cyc + 1;
    step(1'b1, 1'b0); idle(3); step(1'b1, 1'b0); idle(14);
    cmp("pin_seam_oe8", 32'(ctl(s+8, B_OE)), 32'd1);
    cmp("pin_seam_oe9", 32'(ctl(s+9, B_OE)), 32'd1);
    cmp("pin_seam_rd10", 32'(ctl(s+10, B_RD)), 32'd1);
    cmp("pin_seam_rd11", 32'(ctl(s+11, B_RD)), 32'd0);
    cmp("pin_seam_done13", 32'(ctl(s+13, B_DONE)), 32'd1);

    // Starts five cycles apart, leaving a one-cycle gap.
    s = cyc + 1;
    step(1'b1, 1'b0); idle(4); step(1'b1, 1'b0); idle(15);
    cmp("pin_gap_oe9", 32'(ctl(s+9, B_OE)), 32'd0);
    cmp("pin_gap_dqs9", 32'(ctl(s+9, B_DQS)), 32'd1);
    cmp("pin_gap_oe10", 32'(ctl(s+10, B_OE)), 32'd1);

    // tCCD violation: second start two cycles after the first.
    s = cyc + 1;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); idle(14);
    nrd = 0;
    for (int i = s; i <= s + 14; i++) nrd += int'(ctl(i, B_RD));
    cmp("pin_tccd_reads", 32'(nrd), 32'd4);
    cmp("pin_tccd_err2", 32'(ctl(s+2, B_ERR)), 32'd0);
    cmp("pin_tccd_err3", 32'(ctl(s+3, B_ERR)), 32'd1);
    cmp("pin_tccd_sticky", 32'(ctl(s+14, B_ERR)), 32'd1);

    // Reset mid-burst, then a fresh start behaves like a single burst.
    s = cyc + 1;
    step(1'b1, 1'b0); idle(5); step(1'b0, 1'b1);
    mode_dir = 1'b0;
    step(1'b0, 1'b0);
    mode_dir = 1'b1; tbl_idx = 0;
    step(1'b1, 1'b0);
    idle(12);
    mode_dir = 1'b0;
    cmp("pin_rst_oe6", 32'(ctl(s+6, B_OE)), 32'd0);
    cmp("pin_rst_busy6", 32'(ctl(s+6, B_BUSY)), 32'd0);
    cmp("pin_rst_nodone", 32'(ctl(s+9, B_DONE)), 32'd0);
    cmp("pin_rst_err", 32'(ctl(s+6, B_ERR)), 32'd0);
    cmp("pin_rst_p0", 32'(ob_p0[s+13]), 32'h1111);
    cmp("pin_rst_done", 32'(ctl(s+17, B_DONE)), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr100_wr_sched.md
# ddr100_wr_sched

Write-burst scheduler for the 100 MHz DDR PHY. It takes write-start pulses from the command sequencer and counts out the write latency. It fetches burst data from the write-data buffer and drives the per-cycle p0/p1 data and mask beats, DQ output-enable and DQS enable/preamble/postamble into the DQ, DM and DQS lane instances. Several bursts can be in flight at once, including seamless back-to-back bursts at tCCD = 4 cycles.

## Interface
Parameters:
- DQ_WIDTH, 16, data pins driven per beat.
- DM_WIDTH, 2, mask pins (one per byte lane).
- WL, 5, write latency in clk100m cycles from wr_start to first data cycle; legal range 3..15.

Ports:
- clk100m  in  1  sole clock; all logic on rising edge.
- phy_rst  in  1  synchronous, active-high reset.
- wr_start  in  1  one-cycle pulse, same cycle the WRITE command is issued to DRAM.
- wd_rd  out  1  read strobe to write-data buffer; buffer returns data one cycle later.
- wd_data  in  2*DQ_WIDTH  buffer data; [DQ_WIDTH-1:0] = p0 beat, upper half = p1 beat.
- wd_mask  in  2*DM_WIDTH  buffer mask, same packing; 1 = byte masked.
- wdata_p0, wdata_p1  out  DQ_WIDTH each  beats to DQ lanes.
- wdm_p0, wdm_p1  out  DM_WIDTH each  beats to DM lanes.
- dq_oe  out  1  DQ output enable.
- dqs_oe  out  1  DQS output enable (covers preamble and postamble).
- dqs_en  out  1  DQS toggling enable.
- busy  out  1  any accepted burst not yet finished.
- wr_done  out  1  one-cycle pulse per completed burst.
- err_tccd  out  1  sticky tCCD violation flag.

## Operation
- An accepted wr_start at edge E0 marks t=0. Cycle n is the interval after edge En. Every output is registered.
- Pending bursts are tracked in a start-pulse shift register WL+5 deep; each output is an OR over a fixed tap window, so overlapping bursts merge without a state machine per burst.
- Per accepted burst:
  - wd_rd high cycles WL-2..WL+1 (4 reads, 2 beats each = BL8).
  - Buffer data arriving in cycle k is registered onto wdata_p*/wdm_p* for cycle k+1, so beats are valid cycles WL..WL+3.
  - dq_oe high WL..WL+3.
  - dqs_en high WL..WL+3.
  - dqs_oe high WL-1..WL+4: one preamble cycle, then data, then one postamble cycle.
  - wr_done high cycle WL+4.
- Idle (no data window active): wdata_p* = 0, wdm_p* = all ones (masked), dq_oe = dqs_en = dqs_oe = 0.
- busy is high from cycle 1 after an accepted start through the burst's wr_done cycle, inclusive.
- tCCD rule: a wr_start within 3 cycles of the last accepted start (delta 1..3) is dropped: no reads, no outputs. err_tccd sets the next cycle and holds until phy_rst.
- Back-to-back at delta = 4: data windows are contiguous. dq_oe, dqs_en and dqs_oe stay high continuously, with no intermediate postamble or preamble; wd_rd stays high 8 cycles.
- Delta = 5: one gap cycle. dq_oe and dqs_en drop for that cycle. dqs_oe stays high because the first burst's postamble coincides with the second burst's preamble.
- Delta ≥ 6: each burst is fully independent.

## Timing
- Reset values (cycle after phy_rst edge):
  - wd_rd, dq_oe, dqs_oe, dqs_en, busy, wr_done, err_tccd = 0.
  - wdata_p* = 0; wdm_p* = all ones.
  - Shift register cleared.
- phy_rst mid-burst aborts all pending bursts: outputs return to reset values at the next edge, and no wr_done is issued for aborted bursts.
- wr_start coincident with phy_rst is ignored.
- Latency from wr_start to first wd_rd: WL-2 cycles. Latency to first data beat: WL cycles. Latency to wr_done: WL+4 cycles.
- Maximum sustained rate: one burst per 4 cycles (100 % data bus).

## Test plan
- Single burst, WL=5:
  - Stimulus: start at E0; buffer returns p0/p1 = 0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666, 0x7777/0x8888 with mask 0.
  - Required: wd_rd cycles 3–6; data beats in that order cycles 5–8 with wdm = 0; dq_oe and dqs_en 5–8; dqs_oe 4–9; wr_done cycle 9; busy 1–9.
- Seamless pair: starts at E0 and E4.
  - Required: wd_rd 3–10; dq_oe and dqs_en 5–12 with no drop; dqs_oe 4–13; wr_done cycles 9 and 13.
- Gap of one: starts at E0 and E5.
  - Required: dq_oe low only in cycle 9; dqs_oe continuous 4–14.
- tCCD violation: starts at E0 and E2.
  - Required: second start ignored; only 4 wd_rd cycles issued; err_tccd = 1 from cycle 3 until reset.
- Masking: buffer mask p1 = 2'b10 in the second read.
  - Required: wdm_p1 = 2'b10 in cycle 6 only; wdm = 2'b11 in every cycle outside 5–8.
- Reset mid-burst: phy_rst asserted at E6 after start at E0.
  - Required: from cycle 6, all outputs at reset values; no wr_done; err_tccd = 0.
  - A new start at E8 then behaves exactly like the single-burst case.
